// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_pkg
// Description : Shared types and constants for the instruction-memory loader.
//               State encoding, program store geometry, length field width,
//               and the NOP word the core substitutes while the store is
//               not yet valid.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

  localparam int          IMEM_DEPTH = 512;
  localparam int          IMEM_LEN_W = 16;
  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

  // ST_CHK is only reachable when IMEM_CHECKSUM_EN is defined; its encoding
  // is kept fixed so both builds share one state map.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } imem_state_t;

  // States in which the loader is consuming stream bytes.
  function automatic logic imem_is_busy(imem_state_t s);
    return (s == ST_LEN_LO) || (s == ST_LEN_HI) ||
           (s == ST_DATA)   || (s == ST_CHK);
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_ram.sv
`default_nettype none
// ============================================================================
// Module      : imem_ram
// Description : DEPTH x 32 program store. One synchronous write port, one
//               asynchronous read port. Contents are not reset.
// Ports       : clock  - write clock
//               we     - write enable
//               waddr  - write word address
//               wdata  - write data
//               raddr  - read word address
//               rdata  - read data (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module imem_ram
  import imem_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = 9
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Instruction-memory responder for the SLRV core. Loads the
//               program store from a handshaked byte stream framed as a
//               16-bit little-endian word count followed by little-endian
//               32-bit words, and serves the core's combinational fetch port.
//               insMemEn rises only after a complete, valid load.
// Config      : IMEM_CHECKSUM_EN - when defined, a trailing byte equal to the
//               XOR of all data bytes must follow the data, else the load
//               ends in ERR.
// Ports       : wb_clk_i     - clock
//               reset_n      - asynchronous active-low reset
//               load_start   - one-cycle pulse, begins/restarts a load
//               byte_valid   - stream byte offered
//               byte_data    - stream byte
//               byte_ready   - loader accepts a byte this cycle
//               insMemAddr   - fetch word address
//               insMemDataIn - fetched instruction word
//               insMemEn     - program valid
//               load_busy    - load in progress
//               load_err     - last load failed
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = 9
) (
  input  logic              wb_clk_i,
  input  logic              reset_n,
  input  logic              load_start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic [ADDR_W-1:0] insMemAddr,
  output logic [31:0]       insMemDataIn,
  output logic              insMemEn,
  output logic              load_busy,
  output logic              load_err
);

  localparam logic [IMEM_LEN_W-1:0] LEN_DEPTH = IMEM_LEN_W'(DEPTH);
  localparam logic [IMEM_LEN_W-1:0] LEN_ONE   = IMEM_LEN_W'(1);

  imem_state_t           r_state;
  imem_state_t           w_state_nxt;
  logic [IMEM_LEN_W-1:0] r_len;
  logic [IMEM_LEN_W-1:0] r_word_cnt;
  logic [1:0]            r_byte_cnt;
  logic [23:0]           r_asm;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_we;
  logic                  w_last_word;
  logic [IMEM_LEN_W-1:0] w_len_full;
  imem_state_t           w_after_data;

`ifdef IMEM_CHECKSUM_EN
  logic [7:0]            r_csum;
  assign w_after_data = ST_CHK;
`else
  assign w_after_data = ST_DONE;
`endif

  // A restart in the same cycle as an offered byte drops the byte.
  assign w_accept    = byte_valid & w_ready & ~load_start;
  // Full count as it will be once the high byte currently on the bus lands.
  assign w_len_full  = {byte_data, r_len[7:0]};
  assign w_last_word = (r_word_cnt == (r_len - LEN_ONE));
  assign w_we        = w_accept && (r_state == ST_DATA) && (r_byte_cnt == 2'd3);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and status outputs; all outputs decode from state only, so
  // byte_ready never depends on byte_valid.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = imem_is_busy(r_state);
    byte_ready  = w_ready;
    load_busy   = w_ready;
    insMemEn    = (r_state == ST_DONE);
    load_err    = (r_state == ST_ERR);

    if (load_start) begin
      w_state_nxt = ST_LEN_LO;
    end else if (w_accept) begin
      case (r_state)
        ST_LEN_LO: w_state_nxt = ST_LEN_HI;
        ST_LEN_HI: begin
          if (w_len_full > LEN_DEPTH) begin
            w_state_nxt = ST_ERR;
          end else if (w_len_full == '0) begin
            w_state_nxt = w_after_data;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end
        ST_DATA: begin
          if ((r_byte_cnt == 2'd3) && w_last_word) begin
            w_state_nxt = w_after_data;
          end
        end
`ifdef IMEM_CHECKSUM_EN
        ST_CHK: w_state_nxt = (byte_data == r_csum) ? ST_DONE : ST_ERR;
`endif
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Length capture, word assembly and counters
  // --------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_len      <= '0;
      r_word_cnt <= '0;
      r_byte_cnt <= '0;
      r_asm      <= '0;
    end else if (load_start) begin
      r_len      <= '0;
      r_word_cnt <= '0;
      r_byte_cnt <= '0;
      r_asm      <= '0;
    end else if (w_accept) begin
      case (r_state)
        ST_LEN_LO: r_len[7:0]  <= byte_data;
        ST_LEN_HI: r_len[15:8] <= byte_data;
        ST_DATA: begin
          r_byte_cnt <= r_byte_cnt + 2'd1;
          case (r_byte_cnt)
            2'd0:    r_asm[7:0]   <= byte_data;
            2'd1:    r_asm[15:8]  <= byte_data;
            2'd2:    r_asm[23:16] <= byte_data;
            default: r_word_cnt   <= r_word_cnt + LEN_ONE;
          endcase
        end
        default: ;
      endcase
    end
  end

`ifdef IMEM_CHECKSUM_EN
  // Running XOR of data bytes only; length bytes never enter it.
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_csum <= '0;
    end else if (load_start) begin
      r_csum <= '0;
    end else if (w_accept && (r_state == ST_DATA)) begin
      r_csum <= r_csum ^ byte_data;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Program store; the fourth byte goes straight from the bus into [31:24].
  // --------------------------------------------------------------------------
  imem_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock (wb_clk_i),
    .we    (w_we),
    .waddr (r_word_cnt[ADDR_W-1:0]),
    .wdata ({byte_data, r_asm}),
    .raddr (insMemAddr),
    .rdata (insMemDataIn)
  );

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader. Expected fetch words are
//               queued as each load is driven and compared when read back.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;
  import imem_pkg::*;

  logic        wb_clk_i     = 1'b0;
  logic        reset_n      = 1'b0;
  logic        load_start   = 1'b0;
  logic        byte_valid   = 1'b0;
  logic [7:0]  byte_data    = 8'h00;
  logic        byte_ready;
  logic [8:0]  insMemAddr   = '0;
  logic [31:0] insMemDataIn;
  logic        insMemEn;
  logic        load_busy;
  logic        load_err;

  imem_loader #(.DEPTH(512), .ADDR_W(9)) dut (
    .wb_clk_i     (wb_clk_i),
    .reset_n      (reset_n),
    .load_start   (load_start),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .insMemAddr   (insMemAddr),
    .insMemDataIn (insMemDataIn),
    .insMemEn     (insMemEn),
    .load_busy    (load_busy),
    .load_err     (load_err)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic [8:0]  addr;
    logic [31:0] data;
  } sb_t;

  sb_t         sb_q[$];
  logic [31:0] words[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k = 0;
    @(negedge wb_clk_i);
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && k < 20) begin
      @(negedge wb_clk_i);
      k++;
    end
    if (!byte_ready) check("ready_timeout", 32'(byte_ready), 32'd1);
    @(posedge wb_clk_i);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8]);
  endtask

  task automatic pulse_start(input bit with_byte);
    @(negedge wb_clk_i);
    load_start = 1'b1;
    if (with_byte) begin
      byte_valid = 1'b1;
      byte_data  = 8'h77;
    end
    @(posedge wb_clk_i);
    #1;
    load_start = 1'b0;
    byte_valid = 1'b0;
  endtask

  // Sends a complete frame from 'words'; queues expected reads.
  task automatic run_load(input bit push_all);
    logic [15:0] n;
    logic [7:0]  x;
    n = 16'(words.size());
    x = 8'h00;
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    foreach (words[i]) begin
      send_word(words[i]);
      x = x ^ words[i][7:0] ^ words[i][15:8] ^ words[i][23:16] ^ words[i][31:24];
      if (push_all || i == 0 || i == 255 || i == words.size() - 1)
        sb_q.push_back('{addr: 9'(i), data: words[i]});
    end
`ifdef IMEM_CHECKSUM_EN
    send_byte(x);
`endif
  endtask

  task automatic drain();
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      insMemAddr = e.addr;
      #1;
      check($sformatf("rd@%0d", e.addr), insMemDataIn, e.data);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w0, w1;
    logic [7:0]  x;
    int          gap_at;

    // Reset state
    #12;
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_en",    32'(insMemEn),   32'd0);
    check("rst_busy",  32'(load_busy),  32'd0);
    check("rst_err",   32'(load_err),   32'd0);
    @(negedge wb_clk_i);
    reset_n = 1'b1;

    // Basic two-word load
    pulse_start(1'b0);
    check("basic_busy", 32'(load_busy), 32'd1);
    words = {32'h0010_0513, 32'h0020_0593};
    sb_q.push_back('{addr: 9'd0, data: 32'h0010_0513});
    sb_q.push_back('{addr: 9'd1, data: 32'h0020_0593});
    run_load(1'b0);
    check("basic_en",    32'(insMemEn),   32'd1);
    check("basic_busy0", 32'(load_busy),  32'd0);
    check("basic_ready", 32'(byte_ready), 32'd0);
    drain();

    // Backpressure: three idle cycles inside word 0
    w0 = 32'h1122_3344;
    w1 = 32'h5566_7788;
    gap_at = $urandom_range(1, 3);
    pulse_start(1'b0);
    send_byte(8'h02);
    send_byte(8'h00);
    for (int j = 0; j < 4; j++) begin
      if (j == gap_at) begin
        repeat (3) begin
          @(posedge wb_clk_i);
          #1;
          check("bp_ready", 32'(byte_ready), 32'd1);
        end
      end
      send_byte(w0[8*j +: 8]);
    end
    send_word(w1);
    x = 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44 ^ 8'h55 ^ 8'h66 ^ 8'h77 ^ 8'h88;
`ifdef IMEM_CHECKSUM_EN
    send_byte(x);
`endif
    sb_q.push_back('{addr: 9'd0, data: w0});
    sb_q.push_back('{addr: 9'd1, data: w1});
    check("bp_en", 32'(insMemEn), 32'd1);
    drain();

    // Zero-length load completes and leaves memory untouched
    pulse_start(1'b0);
    words = {};
    run_load(1'b0);
    check("n0_en", 32'(insMemEn), 32'd1);
    sb_q.push_back('{addr: 9'd0, data: w0});
    sb_q.push_back('{addr: 9'd1, data: w1});
    drain();

    // Oversize length 513
    pulse_start(1'b0);
    send_byte(8'h01);
    send_byte(8'h02);
    check("ovr_err",   32'(load_err),   32'd1);
    check("ovr_en",    32'(insMemEn),   32'd0);
    check("ovr_ready", 32'(byte_ready), 32'd0);
    check("ovr_busy",  32'(load_busy),  32'd0);

    // Maximum length 512 fills the whole store
    pulse_start(1'b0);
    check("max_errclr", 32'(load_err), 32'd0);
    words = {};
    for (int i = 0; i < 512; i++) words.push_back({i[15:0] ^ 16'hA5A5, i[15:0]});
    run_load(1'b0);
    check("max_en", 32'(insMemEn), 32'd1);
    drain();

    // Abort after five data bytes, restart colliding with an offered byte
    pulse_start(1'b0);
    send_byte(8'h02);
    send_byte(8'h00);
    for (int j = 1; j <= 5; j++) send_byte(8'(j));
    check("abort_busy", 32'(load_busy), 32'd1);
    check("abort_en",   32'(insMemEn),  32'd0);
    pulse_start(1'b1);
    words = {32'hDEAD_BEEF};
    run_load(1'b0);
    // Word 1 never completed before the abort, so it keeps its old contents.
    sb_q.push_back('{addr: 9'd1, data: {16'd1 ^ 16'hA5A5, 16'd1}});
    check("restart_en", 32'(insMemEn), 32'd1);
    drain();

    // Asynchronous reset in the middle of DATA
    pulse_start(1'b0);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(negedge wb_clk_i);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_ready", 32'(byte_ready), 32'd0);
    check("arst_busy",  32'(load_busy),  32'd0);
    check("arst_en",    32'(insMemEn),   32'd0);
    check("arst_err",   32'(load_err),   32'd0);
    @(negedge wb_clk_i);
    reset_n = 1'b1;
    repeat (2) @(posedge wb_clk_i);
    #1;
    check("arst_idle", 32'(load_busy), 32'd0);
    pulse_start(1'b0);
    check("arst_restart", 32'(load_busy), 32'd1);

`ifdef IMEM_CHECKSUM_EN
    // Checksum match and mismatch
    pulse_start(1'b0);
    send_byte(8'h01); send_byte(8'h00);
    send_word(32'h0010_0513);
    send_byte(8'h06);
    check("csum_ok_en", 32'(insMemEn), 32'd1);
    pulse_start(1'b0);
    send_byte(8'h01); send_byte(8'h00);
    send_word(32'h0010_0513);
    send_byte(8'h07);
    check("csum_bad_err", 32'(load_err), 32'd1);
    check("csum_bad_en",  32'(insMemEn), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
